// File: rtl/gf180mcu_ocd_io__bi_seq.sv
// Bidirectional pad sequencer: serialises TX bits onto a GF180 I/O cell and
// samples its receiver, guaranteeing turnaround gaps so OE and IE never overlap.
module gf180mcu_ocd_io__bi_seq #(
  parameter int unsigned TURN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic       tx_data,
  output logic       tx_ready,
  input  logic       rx_req,
  output logic       rx_valid,
  output logic       rx_data,
  input  logic       cfg_we,
  input  logic [5:0] cfg_data,
  output logic       busy,
  output logic       oe,
  output logic       ie,
  output logic       a,
  output logic       pu,
  output logic       pd,
  output logic       pdrv0,
  output logic       pdrv1,
  output logic       sl,
  output logic       cs,
  input  logic       y
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN_TX = 3'd1,
    DRIVE   = 3'd2,
    TURN_RX = 3'd3,
    SAMPLE  = 3'd4
  } state_t;

  // Counters hold "cycles remaining minus one", so a state exits when they hit zero.
  localparam logic [3:0] TURN_LD   = 4'(TURN - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [5:0] cfg_q;
  logic       hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_req) begin
          state_d = SAMPLE;
        end else if (tx_valid) begin
          state_d = TURN_TX;
        end
      end
      TURN_TX: begin
        if (cnt_q == '0) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!hs) begin
          state_d = TURN_RX;
        end
      end
      TURN_RX: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oe       = 1'b0;
    ie       = 1'b0;
    busy     = 1'b1;
    tx_ready = 1'b0;
    case (state_q)
      IDLE: begin
        ie       = 1'b1;
        busy     = 1'b0;
        tx_ready = !rx_req;
      end
      DRIVE: begin
        oe       = 1'b1;
        tx_ready = !rx_req;
      end
      SAMPLE: begin
        ie = 1'b1;
      end
      default: begin
        oe = 1'b0;
      end
    endcase
    hs = tx_valid && tx_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      case (state_d)
        TURN_TX, TURN_RX: cnt_q <= TURN_LD;
        SAMPLE:           cnt_q <= SETTLE_LD;
        default:          cnt_q <= '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 1'b0;
      cfg_q    <= '0;
    end else begin
      rx_valid <= (state_q == SAMPLE) && (state_d == IDLE);
      if ((state_q == SAMPLE) && (cnt_q == '0)) begin
        rx_data <= y;
      end
      if (hs) begin
        a <= tx_data;
      end
      if ((state_q == IDLE) && cfg_we) begin
        cfg_q <= cfg_data;
      end
    end
  end

  // Pulls are suppressed while driving, and a contradictory PU+PD setting disables both.
  always_comb begin
    pdrv1 = cfg_q[5];
    pdrv0 = cfg_q[4];
    sl    = cfg_q[3];
    cs    = cfg_q[2];
    pu    = cfg_q[1] && !cfg_q[0] && (state_q != DRIVE);
    pd    = cfg_q[0] && !cfg_q[1] && (state_q != DRIVE);
  end

endmodule

// File: tb/tb_gf180mcu_ocd_io__bi_seq.sv
// Bench for the pad sequencer: transactions are expanded into expected per-cycle
// pad waveforms from their timing rules and compared every cycle.
module tb_gf180mcu_ocd_io__bi_seq;

  localparam int unsigned TURN   = 2;
  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic       tx_data;
  logic       tx_ready;
  logic       rx_req;
  logic       rx_valid;
  logic       rx_data;
  logic       cfg_we;
  logic [5:0] cfg_data;
  logic       busy;
  logic       oe;
  logic       ie;
  logic       a;
  logic       pu;
  logic       pd;
  logic       pdrv0;
  logic       pdrv1;
  logic       sl;
  logic       cs;
  logic       y;

  int         tests = 0;
  int         fails = 0;
  string      phase = "init";

  logic [5:0] m_cfg;
  logic       m_a;
  logic       m_rxd;
  logic       y_fix_en = 1'b0;
  logic       y_fix    = 1'b0;

  gf180mcu_ocd_io__bi_seq #(
    .TURN  (TURN),
    .SETTLE(SETTLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .rx_req  (rx_req),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .cfg_we  (cfg_we),
    .cfg_data(cfg_data),
    .busy    (busy),
    .oe      (oe),
    .ie      (ie),
    .a       (a),
    .pu      (pu),
    .pd      (pd),
    .pdrv0   (pdrv0),
    .pdrv1   (pdrv1),
    .sl      (sl),
    .cs      (cs),
    .y       (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic txv, input logic txd, input logic rxr,
                     input logic eoe, input logic eie, input logic ebusy,
                     input logic erxv, input logic etxr);
    logic pu_e;
    logic pd_e;
    tx_valid = txv;
    tx_data  = txd;
    rx_req   = rxr;
    y        = y_fix_en ? y_fix : 1'($urandom_range(0, 1));
    pu_e     = m_cfg[1] & ~m_cfg[0] & ~eoe;
    pd_e     = m_cfg[0] & ~m_cfg[1] & ~eoe;
    @(negedge clk);
    check("oe", 8'(oe), 8'(eoe));
    check("ie", 8'(ie), 8'(eie));
    check("oe_ie_excl", 8'(oe & ie), 8'h00);
    check("busy", 8'(busy), 8'(ebusy));
    check("rx_valid", 8'(rx_valid), 8'(erxv));
    check("tx_ready", 8'(tx_ready), 8'(etxr));
    check("a", 8'(a), 8'(m_a));
    check("rx_data", 8'(rx_data), 8'(m_rxd));
    check("pad_cfg", 8'({pdrv1, pdrv0, sl, cs, pu, pd}),
          8'({m_cfg[5], m_cfg[4], m_cfg[3], m_cfg[2], pu_e, pd_e}));
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_cfg = '0;
    m_a   = 1'b0;
    m_rxd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cfg_we   = 1'($urandom_range(0, 1));
      cfg_data = 6'($urandom);
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 1'($urandom_range(0, 1));
      rx_req   = 1'($urandom_range(0, 1));
      y        = 1'($urandom_range(0, 1));
      if (i == 1) begin
        @(negedge clk);
        check("rst_oe", 8'(oe), 8'h00);
        check("rst_ie", 8'(ie), 8'h01);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_rx_valid", 8'(rx_valid), 8'h00);
        check("rst_rx_data", 8'(rx_data), 8'h00);
        check("rst_a", 8'(a), 8'h00);
        check("rst_pad_cfg", 8'({pdrv1, pdrv0, sl, cs, pu, pd}), 8'h00);
        check("rst_tx_ready", 8'(tx_ready), 8'(!rx_req));
      end
      @(posedge clk);
      #1;
    end
    rst    = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic cfg_write(input logic [5:0] d);
    cfg_we   = 1'b1;
    cfg_data = d;
    idle_cyc();
    m_cfg = d;
  endtask

  // SETTLE sampling cycles then the RX_VALID cycle; "again" keeps the request up once more.
  task automatic sample_tail(input logic hold, input logic again);
    logic last;
    logic rq;
    int   rounds;
    last   = 1'b0;
    rounds = again ? 2 : 1;
    for (int r = 0; r < rounds; r++) begin
      for (int s = 0; s < int'(SETTLE); s++) begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (r == 0) ? hold : 1'b0,
            1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        last = y;
      end
      m_rxd = last;
      rq    = (r + 1 < rounds);
      cyc(1'b0, 1'b0, rq, 1'b0, 1'b1, 1'b0, 1'b1, !rq);
    end
  endtask

  task automatic rx_txn(input logic again);
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sample_tail(1'b0, again);
  endtask

  // coll / rst_at: drive-cycle index of an RX collision or reset, -1 for none.
  task automatic tx_burst(input int n, input logic [3:0] bits, input int coll,
                          input int rst_at, input logic busy_we);
    logic more;
    logic col;
    logic nb;
    logic collided;
    logic stop;
    collided = 1'b0;
    stop     = 1'b0;
    cyc(1'b1, bits[0], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    m_a = bits[0];
    for (int t = 0; t < int'(TURN); t++) begin
      if (busy_we && t == 0) begin
        cfg_we   = 1'b1;
        cfg_data = 6'($urandom);
      end
      cyc(n > 1, bits[1], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (!stop && !collided) begin
        more = (i + 1 < n);
        col  = (coll == i);
        nb   = more ? bits[i+1] : 1'b0;
        if (rst_at == i) begin
          rst = 1'b1;
        end
        cyc(more, nb, col, 1'b1, 1'b0, 1'b1, 1'b0, !col);
        if (rst_at == i) begin
          rst   = 1'b0;
          m_a   = 1'b0;
          m_cfg = '0;
          m_rxd = 1'b0;
          stop  = 1'b1;
          idle_cyc();
        end else if (col) begin
          collided = 1'b1;
        end else if (more) begin
          m_a = bits[i+1];
        end
      end
    end
    if (!stop) begin
      for (int t = 0; t < int'(TURN); t++) begin
        cyc(1'b0, 1'b0, collided, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      if (collided) begin
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sample_tail(1'b1, 1'b0);
      end else begin
        idle_cyc();
      end
    end
  endtask

  initial begin
    int          n;
    int          kind;
    int          coll;
    int          rat;
    logic [3:0]  bits;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 1'b0;
    rx_req   = 1'b0;
    cfg_we   = 1'b0;
    cfg_data = '0;
    y        = 1'b0;
    m_cfg    = '0;
    m_a      = 1'b0;
    m_rxd    = 1'b0;

    phase = "reset";
    do_reset();
    idle_cyc();

    phase = "cfg_pu_pd_both";
    cfg_write(6'b000011);
    idle_cyc();
    phase = "cfg_pu_only";
    cfg_write(6'b000010);
    idle_cyc();

    phase = "tx_single";
    tx_burst(1, 4'b0001, -1, -1, 1'b0);
    phase = "tx_burst_101";
    tx_burst(3, 4'b0101, -1, -1, 1'b0);

    phase = "rx_single";
    y_fix_en = 1'b1;
    y_fix    = 1'b1;
    rx_txn(1'b0);
    idle_cyc();
    y_fix_en = 1'b0;
    phase = "rx_back_to_back";
    rx_txn(1'b1);
    idle_cyc();

    phase = "collision";
    tx_burst(3, 4'b0111, 1, -1, 1'b0);
    idle_cyc();

    phase = "cfg_while_busy";
    tx_burst(2, 4'b0010, -1, -1, 1'b1);
    idle_cyc();

    phase = "rst_mid_drive";
    cfg_write(6'b111110);
    tx_burst(4, 4'b1011, -1, 1, 1'b0);

    phase = "random";
    repeat (60) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: cfg_write(6'($urandom));
        1: idle_cyc();
        2: rx_txn(1'($urandom_range(0, 1)));
        default: begin
          n    = $urandom_range(1, 4);
          bits = 4'($urandom);
          coll = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
          rat  = (coll < 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
          tx_burst(n, bits, coll, rat, 1'($urandom_range(0, 1)));
        end
      endcase
    end

    phase = "final_reset";
    do_reset();
    idle_cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf180mcu_ocd_io__bi_seq.md
GF180MCU_OCD_IO__BI_SEQ -- requirements
Module: gf180mcu_ocd_io__bi_seq

Interface
REQ-001 Parameter TURN, default 2: dead cycles with OE=0 and IE=0 at every direction change; legal range 1..15.
REQ-002 Parameter SETTLE, default 2: cycles IE is held before Y is captured; legal range 1..15.
REQ-003 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 TX_VALID  input  1  requester has a bit to drive.
REQ-006 TX_DATA  input  1  bit to drive onto the pad.
REQ-007 TX_READY  output  1  bit accepted when TX_VALID=1 and TX_READY=1 in the same cycle.
REQ-008 RX_REQ  input  1  level request for one pad sample.
REQ-009 RX_VALID  output  1  one-cycle pulse; RX_DATA is valid.
REQ-010 RX_DATA  output  1  captured pad value.
REQ-011 CFG_WE  input  1  configuration write strobe.
REQ-012 CFG_DATA  input  6  {PDRV1,PDRV0,SL,CS,PU,PD}.
REQ-013 BUSY  output  1  high when the FSM is not in IDLE.
REQ-014 OE, IE, A, PU, PD, PDRV0, PDRV1, SL, CS  output  1 each  pad cell controls.
REQ-015 Y  input  1  pad cell receiver output.

Function
REQ-016 FSM states SHALL be IDLE, TURN_TX, DRIVE, TURN_RX and SAMPLE; all pad-control outputs SHALL be registered or decoded from the state register (Moore).
REQ-017 In IDLE the outputs SHALL be OE=0 and IE=1.
- TX_READY = !RX_REQ.
- RX_REQ=1 -> SAMPLE.
- Else TX_VALID=1 -> latch A<=TX_DATA, then TURN_TX.
REQ-018 In TURN_TX the outputs SHALL be OE=0 and IE=0 for exactly TURN cycles; A already shows the latched bit; next state is DRIVE.
REQ-019 In DRIVE the outputs SHALL be OE=1 and IE=0, with TX_READY = !RX_REQ.
- Handshake -> A<=TX_DATA next cycle and remain in DRIVE.
- No handshake -> TURN_RX.
- Each bit is driven for at least 1 cycle.
REQ-020 In TURN_RX the outputs SHALL be OE=0 and IE=0 for exactly TURN cycles, with A held; next state is IDLE.
REQ-021 In SAMPLE the outputs SHALL be OE=0 and IE=1 for SETTLE cycles.
- On the last cycle, RX_DATA<=Y.
- The next cycle is IDLE with RX_VALID=1 for exactly 1 cycle.
REQ-022 RX SHALL have priority over TX.
- RX_REQ=1 in DRIVE forces TX_READY=0 and exits through TURN_RX to IDLE, then SAMPLE.
- If RX_REQ is still high in the RX_VALID cycle, a new sample starts; requesters deassert on RX_VALID.
REQ-023 OE=1 and IE=1 SHALL never both be true in the same cycle; every OE 0->1 and OE 1->0 transition SHALL be separated from IE=1 by >= TURN cycles with IE=0.
REQ-024 The configuration register SHALL be written on CFG_WE=1 only in IDLE and take effect on the next cycle; CFG_WE in any other state SHALL be ignored.
REQ-025 PDRV0, PDRV1, SL and CS SHALL follow the configuration register directly.
REQ-026 PU and PD SHALL equal the configuration bits, except:
- Both forced to 0 whenever OE=1.
- Both forced to 0 when the configuration holds PU=1 and PD=1.
REQ-027 The TURN and SETTLE counters SHALL be 4 bits wide and reload on every state entry; wrap-around is not reachable in the legal range.

Reset
REQ-028 With RST=1 at a clock edge, the next cycle SHALL have:
- state=IDLE, OE=0, IE=1, A=0.
- Configuration=0, so PU=PD=PDRV0=PDRV1=SL=CS=0.
- RX_VALID=0, RX_DATA=0, BUSY=0, counters cleared.
REQ-029 RST SHALL override all states, including DRIVE mid-transfer: OE=0 in the cycle after the RST edge; pending bits and requests are dropped.

Verification (TURN=2, SETTLE=2, cycle 0 = request cycle)
REQ-030 Reset: RST=1 for 2 cycles with random inputs -> OE=0, IE=1, PU=PD=0, BUSY=0, RX_VALID=0.
REQ-031 Single TX bit: TX_VALID=1 and TX_DATA=1 for 1 cycle ->
- Cycles 1-2: OE=0, IE=0, A=1.
- Cycle 3: OE=1, A=1.
- Cycles 4-5: OE=0, IE=0.
- Cycle 6: IE=1, BUSY=0.
REQ-032 Burst: TX_VALID held for 3 bits 1,0,1 -> A=1,0,1 on consecutive DRIVE cycles 3,4,5 with OE=1 throughout, then TURN_RX for cycles 6-7.
REQ-033 RX: Y=1, RX_REQ pulsed high in cycle 0 and dropped on RX_VALID ->
- Cycles 1-2: SAMPLE.
- Cycle 3: RX_VALID=1, RX_DATA=1.
- No second sample follows.
REQ-034 Collision: RX_REQ=1 during a TX burst ->
- TX_READY=0 the same cycle.
- OE=0 next cycle, followed by 2 cycles with IE=0.
- IDLE then SAMPLE; RX_VALID follows.
- Assertion: OE and IE are never both 1 in any cycle.
REQ-035 Config: CFG_DATA=6'b000011 written in IDLE -> PU=PD=0. CFG_DATA=6'b000010 written in IDLE -> PU=1, PD=0, and PU=0 during DRIVE. A write with BUSY=1 is ignored. RST mid-DRIVE -> OE=0 in the next cycle.
